// File: rtl/conv_enc_framer.sv
// conv_enc_framer: rate-1/2 K=4 convolutional encoder with a 1-bit input FIFO
// and 1024-symbol framing (1021 data + 3 zero tail bits per frame).
// Optional macro CONV_ENC_ERR_INJ_EN adds an err_mask input XORed onto d_out.
module conv_enc_framer #(
  parameter logic [3:0] G0         = 4'b1111,
  parameter logic [3:0] G1         = 4'b1101,
  parameter int         FRAME_LEN  = 1024,
  parameter int         TAIL_LEN   = 3,
  parameter int         FIFO_DEPTH = 16,
  parameter int         PRIME_LVL  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic [1:0]                   d_out,
  output logic                         enable,
  output logic                         frame_start,
  output logic [$clog2(FRAME_LEN)-1:0] sym_cnt,
  output logic                         underrun,
`ifdef CONV_ENC_ERR_INJ_EN
  input  logic [1:0]                   err_mask,
`endif
  input  logic                         clr_underrun
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  pos, pos_nx;      // index of the symbol being encoded this cycle
  logic           mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [NW-1:0]  count;
  logic           full, empty, primed, push, pop;
  logic           active, bit_in;
  logic [2:0]     enc_s;
  logic [3:0]     win;
  logic [1:0]     sym;

  assign full    = (count == NW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign primed  = (count >= NW'(PRIME_LVL));
  // Full blocks the push even when a pop happens in the same cycle.
  assign din_ready = ~rst & ~full;
  assign push    = din_valid & din_ready;
  assign pop     = (state == DATA) & ~empty;

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pos   <= '0;
    end else begin
      state <= state_nx;
      pos   <= pos_nx;
    end
  end

  // Next-state logic and selection of the bit fed to the encoder.
  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    active   = 1'b0;
    bit_in   = 1'b0;
    case (state)
      IDLE: begin
        if (primed) begin
          state_nx = DATA;
          pos_nx   = '0;
        end
      end
      DATA: begin
        active = 1'b1;
        bit_in = pop ? mem[rd_ptr] : 1'b0;   // starved: encode a zero
        pos_nx = pos + 1'b1;
        if (pos == CW'(FRAME_LEN - TAIL_LEN - 1)) state_nx = TAIL;
      end
      TAIL: begin
        active = 1'b1;
        pos_nx = pos + 1'b1;                 // wraps FRAME_LEN-1 -> 0
        if (pos == CW'(FRAME_LEN - 1)) state_nx = primed ? DATA : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign win = {bit_in, enc_s};
`ifdef CONV_ENC_ERR_INJ_EN
  assign sym = {^(win & G0), ^(win & G1)} ^ err_mask;
`else
  assign sym = {^(win & G0), ^(win & G1)};
`endif

  // Encoder shift register and registered symbol outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_s       <= '0;
      d_out       <= '0;
      enable      <= 1'b0;
      frame_start <= 1'b0;
      sym_cnt     <= '0;
    end else if (active) begin
      enc_s       <= {bit_in, enc_s[2:1]};
      d_out       <= sym;
      enable      <= 1'b1;
      frame_start <= (pos == '0);
      sym_cnt     <= pos;
    end else begin
      if (state == IDLE && primed) enc_s <= '0;
      d_out       <= '0;
      enable      <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  // Sticky underrun flag; a new underrun wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          underrun <= 1'b0;
    else if (state == DATA && empty)  underrun <= 1'b1;
    else if (clr_underrun)            underrun <= 1'b0;
  end

endmodule

// File: tb/tb_conv_enc_framer.sv
// Directed bench for conv_enc_framer: impulse, underrun, full frame,
// back-to-back frames with async reset, and FIFO backpressure on a
// second instance primed at 16.
module tb_conv_enc_framer;

  logic       clk, rst, din, din_valid, din_ready, enable, frame_start, underrun, clr_underrun;
  logic [1:0] d_out;
  logic [9:0] sym_cnt;
  logic       b_din, b_valid, b_ready, b_en, b_fs, b_unr;
  logic [1:0] b_dout;
  logic [9:0] b_cnt;
`ifdef CONV_ENC_ERR_INJ_EN
  logic [1:0] err_mask;
`endif

  int ncmp = 0;
  int nerr = 0;
  logic bits [0:2047];
  logic pat  [0:63];

  conv_enc_framer dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .d_out(d_out), .enable(enable), .frame_start(frame_start), .sym_cnt(sym_cnt),
    .underrun(underrun),
`ifdef CONV_ENC_ERR_INJ_EN
    .err_mask(err_mask),
`endif
    .clr_underrun(clr_underrun));

  conv_enc_framer #(.PRIME_LVL(16)) dut16 (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
    .d_out(b_dout), .enable(b_en), .frame_start(b_fs), .sym_cnt(b_cnt),
    .underrun(b_unr),
`ifdef CONV_ENC_ERR_INJ_EN
    .err_mask(err_mask),
`endif
    .clr_underrun(clr_underrun));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: {G0=17o parity, G1=15o parity} of {b, state}.
  function automatic logic [1:0] enc(input logic b, input logic [2:0] st);
    logic [3:0] w;
    w = {b, st};
    return {^(w & 4'b1111), ^(w & 4'b1101)};
  endfunction

  // Push a single 1 followed by 7 zeros and check the impulse response.
  task automatic impulse_chk(input string tag);
    logic [1:0] iexp [8];
    iexp = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 8; i++) begin
      din_valid = 1'b1;
      din = (i == 0);
      tick();
    end
    din_valid = 1'b0;
    tick();
    chk({tag, "_prestart"}, enable, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_sym"}, {enable, frame_start, sym_cnt, d_out, underrun},
          {1'b1, k == 0, 10'(k), iexp[k], 1'b0});
      if (k < 7) tick();
    end
  endtask

  // Stream nbits back-to-back at one per cycle and check nsyms symbols.
  task automatic stream_chk(input string tag, input int nbits, input int nsyms);
    fork
      begin
        for (int i = 0; i < nbits; i++) begin
          din_valid = 1'b1;
          din = bits[i];
          tick();
        end
        din_valid = 1'b0;
      end
      begin
        logic [2:0] ms;
        logic       b;
        int         k, bi, w;
        ms = 3'b000;
        w = 0;
        while (!enable && w < 50) begin tick(); w++; end
        chk({tag, "_start"}, enable, 1'b1);
        for (int j = 0; j < nsyms; j++) begin
          k  = j % 1024;
          bi = (j / 1024) * 1021 + k;
          b  = (k < 1021 && bi < nbits) ? bits[bi] : 1'b0;
          chk({tag, "_sym"}, {enable, frame_start, sym_cnt, d_out},
              {1'b1, k == 0, 10'(k), enc(b, ms)});
          ms = {b, ms[2:1]};
          if (j < nsyms - 1) tick();
        end
      end
    join
  endtask

  initial begin
    int         last, idx, w;
    logic       rdy;
    logic [2:0] ms;
    for (int i = 0; i < 2048; i++) bits[i] = 1'($urandom);
    for (int i = 0; i < 64; i++)   pat[i]  = 1'($urandom);
`ifdef CONV_ENC_ERR_INJ_EN
    err_mask = 2'b00;
`endif
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr_underrun = 1'b0;
    b_din = 1'b0; b_valid = 1'b0;
    #3;
    chk("reset_vals", {din_ready, enable, frame_start, sym_cnt, d_out, underrun}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {din_ready, b_ready}, 2'b11);

    // Impulse, then the FIFO runs dry during DATA.
    impulse_chk("imp");
    tick();
    chk("underrun_set", {underrun, d_out, sym_cnt}, {1'b1, 2'b00, 10'd8});
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("underrun_prio", underrun, 1'b1);
    last = 0;
    for (int c = 0; c < 1100; c++) begin
      last = int'(sym_cnt);
      tick();
      if (!enable) break;
    end
    chk("frame_end_cnt", last, 1023);
    chk("idle_out", {enable, d_out}, 3'b000);
    chk("underrun_sticky", underrun, 1'b1);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("underrun_clr", underrun, 1'b0);

    // Backpressure on the instance primed at 16.
    for (int i = 0; i < 16; i++) begin
      chk("bp_ready", b_ready, 1'b1);
      b_valid = 1'b1;
      b_din = pat[i];
      tick();
    end
    chk("bp_full", b_ready, 1'b0);
    idx = 16;
    fork
      begin
        for (int c = 0; c < 44; c++) begin
          b_din = pat[idx];
          rdy = b_ready;
          tick();
          if (rdy) idx++;
        end
        b_valid = 1'b0;
      end
      begin
        ms = 3'b000;
        w = 0;
        while (!b_en && w < 10) begin tick(); w++; end
        chk("bp_start", {b_en, b_fs, b_cnt}, {1'b1, 1'b1, 10'd0});
        for (int k = 0; k < 40; k++) begin
          chk("bp_sym", {b_en, b_dout}, {1'b1, enc(pat[k], ms)});
          ms = {pat[k], ms[2:1]};
          tick();
        end
      end
    join

    // One full frame of random data, then no more input.
    stream_chk("full", 1021, 1024);
    tick();
    chk("full_enable_fall", enable, 1'b0);
    chk("full_no_underrun", underrun, 1'b0);

    // Back-to-back frames; reset asynchronously at symbol 500 of frame 2.
    stream_chk("b2b", 1421, 1525);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {enable, frame_start, sym_cnt, d_out, underrun, din_ready}, 0);
    #3 rst = 1'b0;
    impulse_chk("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
